// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and state encoding for the fetch stage
package fetch_pkg;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] EXC_VEC  = 32'hbfc00380;
    localparam logic [31:0] PC_INC   = 32'd4;

    typedef enum logic [1:0] {
        FS_REQ    = 2'd0,
        FS_WAIT   = 2'd1,
        FS_VALID  = 2'd2,
        FS_CANCEL = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/fetch_if.sv
// rtl/fetch_if.sv - instruction SRAM request/response handshake
interface fetch_if;

    logic        inst_sram_req;
    logic [31:0] inst_sram_addr;
    logic        inst_sram_addr_ok;
    logic        inst_sram_data_ok;
    logic [31:0] inst_sram_rdata;

    modport master (
        output inst_sram_req,
        output inst_sram_addr,
        input  inst_sram_addr_ok,
        input  inst_sram_data_ok,
        input  inst_sram_rdata
    );

    modport slave (
        input  inst_sram_req,
        input  inst_sram_addr,
        output inst_sram_addr_ok,
        output inst_sram_data_ok,
        output inst_sram_rdata
    );

endinterface

// File: rtl/fetch_npc.sv
// rtl/fetch_npc.sv - combinational next-PC selection from exception and branch inputs
module fetch_npc
    import fetch_pkg::*;
#(
    parameter logic [31:0] EXC_ADDR = EXC_VEC
) (
    input  logic        excp,
    input  logic        br_en,
    input  logic        br_taken,
    input  logic        br_is_br,
    input  logic        br_is_j,
    input  logic        br_is_jr,
    input  logic [15:0] br_offset,
    input  logic [25:0] br_index,
    input  logic [31:0] br_target,
    input  logic [31:0] fe_pc,
    output logic [31:0] nextpc
);

    logic [31:0] seq_pc;
    logic [31:0] br_pc;
    logic [31:0] j_pc;
    logic        taken;

    // fe_pc is the delay-slot PC, so all targets are relative to it
    assign seq_pc = fe_pc + PC_INC;
    assign br_pc  = fe_pc + {{14{br_offset[15]}}, br_offset, 2'b00};
    assign j_pc   = {fe_pc[31:28], br_index, 2'b00};
    assign taken  = br_en && br_taken;

    always_comb begin
        nextpc = seq_pc;
        if (excp) begin
            nextpc = EXC_ADDR;
        end else if (taken && br_is_jr) begin
            nextpc = br_target;
        end else if (taken && br_is_j) begin
            nextpc = j_pc;
        end else if (taken && br_is_br) begin
            nextpc = br_pc;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - PC owner issuing one SRAM fetch at a time and holding the word for decode
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = fetch_pkg::RESET_PC,
    parameter logic [31:0] EXC_VEC  = fetch_pkg::EXC_VEC
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          excp,
    input  logic          stall,
    input  logic          de_br_taken,
    input  logic          de_br_is_br,
    input  logic          de_br_is_j,
    input  logic          de_br_is_jr,
    input  logic [15:0]   de_br_offset,
    input  logic [25:0]   de_br_index,
    input  logic [31:0]   de_br_target,
    fetch_if.master       sram,
    output logic [31:0]   nextpc,
    output logic [31:0]   fe_pc,
    output logic [31:0]   fe_inst,
    output logic          fe_valid,
    output logic          fe_adel,
    output logic [31:0]   fe_badvaddr
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  fe_inst_q, fe_inst_d;
    logic [31:0]  fe_badvaddr_q, fe_badvaddr_d;
    logic         fe_valid_q, fe_valid_d;
    logic         fe_adel_q, fe_adel_d;
    logic         misaligned;
    logic         handoff;
    logic         req;

    assign misaligned = (pc_q[1:0] != 2'b00);
    assign handoff    = (state_q == FS_VALID) && !stall;
    assign req        = resetn && (state_q == FS_REQ) && !misaligned;

    assign sram.inst_sram_req  = req;
    assign sram.inst_sram_addr = pc_q;

    assign fe_pc       = pc_q;
    assign fe_inst     = fe_inst_q;
    assign fe_valid    = fe_valid_q;
    assign fe_adel     = fe_adel_q;
    assign fe_badvaddr = fe_badvaddr_q;

    fetch_npc #(.EXC_ADDR(EXC_VEC)) u_npc (
        .excp      (excp),
        .br_en     (handoff),
        .br_taken  (de_br_taken),
        .br_is_br  (de_br_is_br),
        .br_is_j   (de_br_is_j),
        .br_is_jr  (de_br_is_jr),
        .br_offset (de_br_offset),
        .br_index  (de_br_index),
        .br_target (de_br_target),
        .fe_pc     (pc_q),
        .nextpc    (nextpc)
    );

    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        fe_inst_d     = fe_inst_q;
        fe_badvaddr_d = fe_badvaddr_q;
        fe_valid_d    = fe_valid_q;
        fe_adel_d     = fe_adel_q;
        case (state_q)
            FS_REQ: begin
                // a misaligned PC never reaches the SRAM; it becomes an error slot
                if (misaligned) begin
                    fe_inst_d     = 32'h0;
                    fe_adel_d     = 1'b1;
                    fe_badvaddr_d = pc_q;
                    fe_valid_d    = 1'b1;
                    state_d       = FS_VALID;
                end else if (sram.inst_sram_addr_ok) begin
                    state_d = FS_WAIT;
                end
            end
            FS_WAIT: begin
                if (sram.inst_sram_data_ok) begin
                    fe_inst_d  = sram.inst_sram_rdata;
                    fe_adel_d  = 1'b0;
                    fe_valid_d = 1'b1;
                    state_d    = FS_VALID;
                end
            end
            FS_VALID: begin
                if (!stall) begin
                    pc_d       = nextpc;
                    fe_valid_d = 1'b0;
                    state_d    = FS_REQ;
                end
            end
            FS_CANCEL: begin
                if (sram.inst_sram_data_ok) begin
                    state_d = FS_REQ;
                end
            end
            default: state_d = FS_REQ;
        endcase

        // an exception must still drain any request the SRAM has accepted
        if (excp) begin
            pc_d       = EXC_VEC;
            fe_valid_d = 1'b0;
            fe_adel_d  = 1'b0;
            case (state_q)
                FS_WAIT:   state_d = sram.inst_sram_data_ok ? FS_REQ : FS_CANCEL;
                FS_CANCEL: state_d = sram.inst_sram_data_ok ? FS_REQ : FS_CANCEL;
                FS_REQ:    state_d = (req && sram.inst_sram_addr_ok) ? FS_CANCEL : FS_REQ;
                default:   state_d = FS_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q       <= FS_REQ;
            pc_q          <= RESET_PC;
            fe_inst_q     <= 32'h0;
            fe_badvaddr_q <= 32'h0;
            fe_valid_q    <= 1'b0;
            fe_adel_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            fe_inst_q     <= fe_inst_d;
            fe_badvaddr_q <= fe_badvaddr_d;
            fe_valid_q    <= fe_valid_d;
            fe_adel_q     <= fe_adel_d;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - directed self-checking bench for fetch_stage
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        resetn;
    logic        excp;
    logic        stall;
    logic        de_br_taken;
    logic        de_br_is_br;
    logic        de_br_is_j;
    logic        de_br_is_jr;
    logic [15:0] de_br_offset;
    logic [25:0] de_br_index;
    logic [31:0] de_br_target;
    logic [31:0] nextpc;
    logic [31:0] fe_pc;
    logic [31:0] fe_inst;
    logic        fe_valid;
    logic        fe_adel;
    logic [31:0] fe_badvaddr;

    int vectors = 0;
    int miscompares = 0;

    fetch_if sram_if ();

    fetch_stage dut (
        .clk          (clk),
        .resetn       (resetn),
        .excp         (excp),
        .stall        (stall),
        .de_br_taken  (de_br_taken),
        .de_br_is_br  (de_br_is_br),
        .de_br_is_j   (de_br_is_j),
        .de_br_is_jr  (de_br_is_jr),
        .de_br_offset (de_br_offset),
        .de_br_index  (de_br_index),
        .de_br_target (de_br_target),
        .sram         (sram_if),
        .nextpc       (nextpc),
        .fe_pc        (fe_pc),
        .fe_inst      (fe_inst),
        .fe_valid     (fe_valid),
        .fe_adel      (fe_adel),
        .fe_badvaddr  (fe_badvaddr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_branch();
        de_br_taken  = 1'b0;
        de_br_is_br  = 1'b0;
        de_br_is_j   = 1'b0;
        de_br_is_jr  = 1'b0;
        de_br_offset = 16'h0;
        de_br_index  = 26'h0;
        de_br_target = 32'h0;
    endtask

    // zero-wait SRAM: accept the request now, return data next cycle; ends in the VALID cycle
    task automatic serve(input logic [31:0] word, output logic [31:0] addr_seen, output logic ok);
        int n = 0;
        ok = 1'b0;
        addr_seen = 32'h0;
        while (!sram_if.inst_sram_req && n < 8) begin
            tick();
            n++;
        end
        if (sram_if.inst_sram_req) begin
            addr_seen = sram_if.inst_sram_addr;
            sram_if.inst_sram_addr_ok = 1'b1;
            tick();
            sram_if.inst_sram_addr_ok = 1'b0;
            sram_if.inst_sram_data_ok = 1'b1;
            sram_if.inst_sram_rdata   = word;
            tick();
            sram_if.inst_sram_data_ok = 1'b0;
            ok = 1'b1;
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        tick();
        tick();
        vectors++;
        if (sram_if.inst_sram_req !== 1'b0) begin miscompares++; $display("FAIL reset_req: got %b want 0", sram_if.inst_sram_req); end
        vectors++;
        if (fe_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", fe_valid); end
        vectors++;
        if ({fe_inst, fe_badvaddr} !== 64'h0) begin miscompares++; $display("FAIL reset_inst_bad: got %h %h want 0 0", fe_inst, fe_badvaddr); end
        vectors++;
        if (fe_adel !== 1'b0) begin miscompares++; $display("FAIL reset_adel: got %b want 0", fe_adel); end
        resetn = 1'b1;
    endtask

    task automatic test_first_fetch();
        logic [31:0] a;
        logic ok;
        serve(32'h24010001, a, ok);
        vectors++;
        if (ok !== 1'b1 || a !== 32'hbfc00000) begin miscompares++; $display("FAIL first_req: got ok=%b addr=%h want 1 bfc00000", ok, a); end
        vectors++;
        if (fe_valid !== 1'b1 || fe_pc !== 32'hbfc00000 || fe_inst !== 32'h24010001) begin
            miscompares++; $display("FAIL first_slot: got v=%b pc=%h inst=%h want 1 bfc00000 24010001", fe_valid, fe_pc, fe_inst);
        end
        vectors++;
        if (fe_adel !== 1'b0 || nextpc !== 32'hbfc00004) begin miscompares++; $display("FAIL first_npc: got adel=%b npc=%h want 0 bfc00004", fe_adel, nextpc); end
        tick();
        vectors++;
        if (sram_if.inst_sram_req !== 1'b1 || sram_if.inst_sram_addr !== 32'hbfc00004 || fe_valid !== 1'b0) begin
            miscompares++; $display("FAIL second_req: got req=%b addr=%h v=%b want 1 bfc00004 0", sram_if.inst_sram_req, sram_if.inst_sram_addr, fe_valid);
        end
    endtask

    task automatic test_branch();
        logic [31:0] a;
        logic ok;
        for (int i = 0; i < 3; i++) begin
            serve(32'h00000000, a, ok);
            tick();
        end
        serve(32'h00000021, a, ok);
        vectors++;
        if (ok !== 1'b1 || fe_valid !== 1'b1 || fe_pc !== 32'hbfc00010) begin
            miscompares++; $display("FAIL br_delay_slot: got ok=%b v=%b pc=%h want 1 1 bfc00010", ok, fe_valid, fe_pc);
        end
        de_br_taken  = 1'b1;
        de_br_is_br  = 1'b1;
        de_br_offset = 16'hfffe;
        #1;
        vectors++;
        if (nextpc !== 32'hbfc00008) begin miscompares++; $display("FAIL br_npc: got %h want bfc00008", nextpc); end
        tick();
        clear_branch();
        vectors++;
        if (sram_if.inst_sram_req !== 1'b1 || sram_if.inst_sram_addr !== 32'hbfc00008) begin
            miscompares++; $display("FAIL br_target_req: got req=%b addr=%h want 1 bfc00008", sram_if.inst_sram_req, sram_if.inst_sram_addr);
        end
    endtask

    task automatic test_jump();
        logic [31:0] a;
        logic ok;
        serve(32'h0800_0040, a, ok);
        de_br_taken = 1'b1;
        de_br_is_j  = 1'b1;
        de_br_index = 26'h0000040;
        tick();
        clear_branch();
        vectors++;
        if (sram_if.inst_sram_addr !== 32'hb0000100 || sram_if.inst_sram_req !== 1'b1) begin
            miscompares++; $display("FAIL j_target: got req=%b addr=%h want 1 b0000100", sram_if.inst_sram_req, sram_if.inst_sram_addr);
        end
    endtask

    task automatic test_misaligned();
        logic [31:0] a;
        logic ok;
        serve(32'h03e00008, a, ok);
        de_br_taken  = 1'b1;
        de_br_is_jr  = 1'b1;
        de_br_target = 32'h80000002;
        tick();
        clear_branch();
        vectors++;
        if (sram_if.inst_sram_req !== 1'b0 || fe_valid !== 1'b0) begin
            miscompares++; $display("FAIL adel_no_req: got req=%b v=%b want 0 0", sram_if.inst_sram_req, fe_valid);
        end
        tick();
        vectors++;
        if (fe_valid !== 1'b1 || fe_adel !== 1'b1 || fe_badvaddr !== 32'h80000002 || fe_inst !== 32'h0) begin
            miscompares++; $display("FAIL adel_slot: got v=%b adel=%b bad=%h inst=%h want 1 1 80000002 0", fe_valid, fe_adel, fe_badvaddr, fe_inst);
        end
        vectors++;
        if (sram_if.inst_sram_req !== 1'b0 || fe_pc !== 32'h80000002) begin
            miscompares++; $display("FAIL adel_pc: got req=%b pc=%h want 0 80000002", sram_if.inst_sram_req, fe_pc);
        end
        de_br_taken  = 1'b1;
        de_br_is_jr  = 1'b1;
        de_br_target = 32'hbfc00100;
        tick();
        clear_branch();
        vectors++;
        if (sram_if.inst_sram_req !== 1'b1 || sram_if.inst_sram_addr !== 32'hbfc00100) begin
            miscompares++; $display("FAIL adel_recover: got req=%b addr=%h want 1 bfc00100", sram_if.inst_sram_req, sram_if.inst_sram_addr);
        end
    endtask

    task automatic test_excp_wait();
        logic [31:0] a;
        logic ok;
        sram_if.inst_sram_addr_ok = 1'b1;
        tick();
        sram_if.inst_sram_addr_ok = 1'b0;
        excp = 1'b1;
        tick();
        excp = 1'b0;
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (sram_if.inst_sram_req !== 1'b0 || fe_valid !== 1'b0) begin
                miscompares++; $display("FAIL cancel_hold[%0d]: got req=%b v=%b want 0 0", i, sram_if.inst_sram_req, fe_valid);
            end
            tick();
        end
        sram_if.inst_sram_data_ok = 1'b1;
        sram_if.inst_sram_rdata   = 32'hdeadbeef;
        tick();
        sram_if.inst_sram_data_ok = 1'b0;
        vectors++;
        if (fe_valid !== 1'b0 || sram_if.inst_sram_req !== 1'b1 || sram_if.inst_sram_addr !== 32'hbfc00380) begin
            miscompares++; $display("FAIL cancel_drop: got v=%b req=%b addr=%h want 0 1 bfc00380", fe_valid, sram_if.inst_sram_req, sram_if.inst_sram_addr);
        end
        serve(32'h3c1a0000, a, ok);
        vectors++;
        if (fe_valid !== 1'b1 || fe_pc !== 32'hbfc00380 || fe_inst !== 32'h3c1a0000) begin
            miscompares++; $display("FAIL exc_slot: got v=%b pc=%h inst=%h want 1 bfc00380 3c1a0000", fe_valid, fe_pc, fe_inst);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (fe_valid !== 1'b1 || fe_pc !== 32'hbfc00380 || fe_inst !== 32'h3c1a0000 || sram_if.inst_sram_req !== 1'b0) begin
                miscompares++; $display("FAIL stall_hold[%0d]: got v=%b pc=%h inst=%h req=%b want 1 bfc00380 3c1a0000 0",
                                        i, fe_valid, fe_pc, fe_inst, sram_if.inst_sram_req);
            end
        end
        stall = 1'b0;
        tick();
        vectors++;
        if (fe_valid !== 1'b0 || sram_if.inst_sram_req !== 1'b1 || sram_if.inst_sram_addr !== 32'hbfc00384) begin
            miscompares++; $display("FAIL stall_release: got v=%b req=%b addr=%h want 0 1 bfc00384", fe_valid, sram_if.inst_sram_req, sram_if.inst_sram_addr);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] a;
        logic ok;
        serve(32'h0, a, ok);
        de_br_taken  = 1'b1;
        de_br_is_jr  = 1'b1;
        de_br_target = 32'hfffffffc;
        tick();
        clear_branch();
        serve(32'h11112222, a, ok);
        vectors++;
        if (fe_pc !== 32'hfffffffc || nextpc !== 32'h00000000) begin
            miscompares++; $display("FAIL wrap_npc: got pc=%h npc=%h want fffffffc 00000000", fe_pc, nextpc);
        end
        tick();
        vectors++;
        if (sram_if.inst_sram_req !== 1'b1 || sram_if.inst_sram_addr !== 32'h00000000) begin
            miscompares++; $display("FAIL wrap_req: got req=%b addr=%h want 1 00000000", sram_if.inst_sram_req, sram_if.inst_sram_addr);
        end
    endtask

    task automatic test_excp_req_accept();
        logic [31:0] a;
        logic ok;
        sram_if.inst_sram_data_ok = 1'b1;
        sram_if.inst_sram_rdata   = 32'h0badc0de;
        tick();
        sram_if.inst_sram_data_ok = 1'b0;
        vectors++;
        if (sram_if.inst_sram_req !== 1'b1 || sram_if.inst_sram_addr !== 32'h0 || fe_valid !== 1'b0) begin
            miscompares++; $display("FAIL stray_data_ok: got req=%b addr=%h v=%b want 1 00000000 0", sram_if.inst_sram_req, sram_if.inst_sram_addr, fe_valid);
        end
        sram_if.inst_sram_addr_ok = 1'b1;
        excp = 1'b1;
        tick();
        sram_if.inst_sram_addr_ok = 1'b0;
        excp = 1'b0;
        vectors++;
        if (sram_if.inst_sram_req !== 1'b0) begin miscompares++; $display("FAIL req_excp_cancel: got req=%b want 0", sram_if.inst_sram_req); end
        sram_if.inst_sram_data_ok = 1'b1;
        tick();
        sram_if.inst_sram_data_ok = 1'b0;
        vectors++;
        if (sram_if.inst_sram_req !== 1'b1 || sram_if.inst_sram_addr !== 32'hbfc00380 || fe_valid !== 1'b0) begin
            miscompares++; $display("FAIL req_excp_refetch: got req=%b addr=%h v=%b want 1 bfc00380 0", sram_if.inst_sram_req, sram_if.inst_sram_addr, fe_valid);
        end
        serve(32'h40806000, a, ok);
        vectors++;
        if (ok !== 1'b1 || fe_pc !== 32'hbfc00380 || fe_inst !== 32'h40806000) begin
            miscompares++; $display("FAIL req_excp_slot: got ok=%b pc=%h inst=%h want 1 bfc00380 40806000", ok, fe_pc, fe_inst);
        end
    endtask

    initial begin
        resetn = 1'b0;
        excp   = 1'b0;
        stall  = 1'b0;
        clear_branch();
        sram_if.inst_sram_addr_ok = 1'b0;
        sram_if.inst_sram_data_ok = 1'b0;
        sram_if.inst_sram_rdata   = 32'h0;
        test_reset();
        test_first_fetch();
        test_branch();
        test_jump();
        test_misaligned();
        test_excp_wait();
        test_stall();
        test_wrap();
        test_excp_req_accept();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
